// File: rtl/bob_ring.sv
// Branch ordering buffer: in-order ring of DEPTH recovery checkpoints with alloc/retire/flush.
// Optional mispredict rewind to a tag is compiled in with `define BOB_SQUASH_EN.
module bob_ring #(
    parameter int DATAW    = 93,
    parameter int DEPTH    = 16,
    parameter int LOGDEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                alloc_vld_i,
    input  logic [DATAW-1:0]    alloc_data_i,
    output logic                alloc_rdy_o,
    output logic [LOGDEPTH-1:0] alloc_tag_o,
    input  logic                retire_i,
    output logic                head_vld_o,
    output logic [DATAW-1:0]    head_data_o,
    output logic [LOGDEPTH-1:0] head_tag_o,
    output logic [LOGDEPTH:0]   count_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                err_o
`ifdef BOB_SQUASH_EN
    ,
    input  logic                squash_i,
    input  logic [LOGDEPTH-1:0] squash_tag_i
`endif
);

    localparam int PTR_W = LOGDEPTH + 1;

    logic [DATAW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]    head_q, tail_q, head_n, tail_n;
    logic                err_q, err_n;
    logic [LOGDEPTH-1:0] head_idx, tail_idx;
    logic [PTR_W-1:0]    count;
    logic                full, empty;
    logic                push_ok, push_err, pop_ok, pop_err, wr_en;
    logic                sq_hit, sq_err;
    logic [PTR_W-1:0]    sq_tail;

    assign head_idx = head_q[LOGDEPTH-1:0];
    assign tail_idx = tail_q[LOGDEPTH-1:0];
    assign count    = tail_q - head_q;
    assign full     = (head_idx == tail_idx) && (head_q[LOGDEPTH] != tail_q[LOGDEPTH]);
    assign empty    = (head_q == tail_q);

    // Handshake: a push transfers when alloc_vld_i && alloc_rdy_o at the rising edge;
    // alloc_rdy_o comes from registered state only, so it never depends on retire_i.
    assign push_ok  = alloc_vld_i && !full;
    assign push_err = alloc_vld_i && full;
    assign pop_ok   = retire_i && !empty;
    assign pop_err  = retire_i && empty;

`ifdef BOB_SQUASH_EN
    logic [LOGDEPTH-1:0] sq_off;
    // Distance of the squashed tag from head; it is live only if it falls below count.
    assign sq_off  = squash_tag_i - head_idx;
    assign sq_hit  = squash_i && !empty && ({1'b0, sq_off} < count);
    assign sq_err  = squash_i && !sq_hit;
    assign sq_tail = head_q + {1'b0, sq_off} + PTR_W'(1);
`else
    assign sq_hit  = 1'b0;
    assign sq_err  = 1'b0;
    assign sq_tail = tail_q;
`endif

    always_comb begin
        head_n = head_q;
        tail_n = tail_q;
        err_n  = err_q;
        wr_en  = 1'b0;
        if (flush) begin
            head_n = '0;
            tail_n = '0;
        end else begin
            if (sq_hit) begin
                tail_n = sq_tail;
            end else if (push_ok) begin
                tail_n = tail_q + PTR_W'(1);
                wr_en  = 1'b1;
            end
            if (pop_ok) begin
                head_n = head_q + PTR_W'(1);
            end
            if ((push_err && !sq_hit) || pop_err || sq_err) begin
                err_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            err_q  <= 1'b0;
        end else begin
            head_q <= head_n;
            tail_q <= tail_n;
            err_q  <= err_n;
        end
    end

    // Payload array is deliberately not reset.
    always_ff @(posedge clock) begin
        if (wr_en && !reset) begin
            mem[tail_idx] <= alloc_data_i;
        end
    end

    assign alloc_rdy_o = !full;
    assign alloc_tag_o = tail_idx;
    assign head_vld_o  = !empty;
    assign head_data_o = mem[head_idx];
    assign head_tag_o  = head_idx;
    assign count_o     = count;
    assign full_o      = full;
    assign empty_o     = empty;
    assign err_o       = err_q;

endmodule

// File: doc/bob_ring.md
Name: bob_ring

Overview:
- Parametrised branch ordering buffer. Successor to the fixed 16x93 BOB in fetch.
- Holds per-branch recovery checkpoints in program order: PC, predictor history, RAS pointer and direction, packed by the caller into DATAW bits.
- Fetch allocates an entry per predicted conditional/indirect branch. Retire frees entries in order. Mispredict recovery rewinds to a given tag.
- Adds over the previous BOB: true full/empty on all DEPTH entries, allocate and retire in the same cycle, in-order tag return, and occupancy and error reporting.

Parameters:
- DATAW, 93, checkpoint payload width in bits.
- DEPTH, 16, number of entries. Must be a power of 2 and >= 2.
- LOGDEPTH, 4, log2(DEPTH). Width of tags.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all entries (pipeline flush)
- alloc_vld_i  in  1  request to push a checkpoint
- alloc_data_i  in  DATAW  checkpoint payload
- alloc_rdy_o  out  1  buffer can accept (not full)
- alloc_tag_o  out  LOGDEPTH  tag given to the push in this cycle (current tail index)
- retire_i  in  1  pop the oldest entry
- head_vld_o  out  1  oldest entry valid (not empty)
- head_data_o  out  DATAW  oldest entry payload
- head_tag_o  out  LOGDEPTH  oldest entry index
- count_o  out  LOGDEPTH+1  occupancy, 0..DEPTH
- full_o  out  1  count_o == DEPTH
- empty_o  out  1  count_o == 0
- err_o  out  1  sticky protocol error
- squash_i  in  1  mispredict rewind (exists only with the macro)
- squash_tag_i  in  LOGDEPTH  tag of the mispredicted branch (exists only with the macro)

Behaviour:
- State: DEPTH x DATAW register array; head and tail pointers of LOGDEPTH+1 bits each, wrap bit in the MSB; err flag.
- Index = pointer[LOGDEPTH-1:0].
- count = tail - head, modulo 2^(LOGDEPTH+1).
- full = (index equal) and (MSBs differ). empty = pointers equal.
- Reset (sync, high), outputs:
  - head = tail = 0, count_o = 0, empty_o = 1, full_o = 0
  - alloc_rdy_o = 1, head_vld_o = 0, alloc_tag_o = 0, head_tag_o = 0
  - err_o = 0
  - Array contents are not cleared. head_data_o is don't-care while empty.
- Reset mid-operation: all entries are discarded next cycle, same as flush.
- alloc_rdy_o = !full. It depends only on registered state, never on retire_i.
- Push:
  - Fires when alloc_vld_i && alloc_rdy_o.
  - Writes array[tail index] at the clock edge; tail++.
  - alloc_tag_o equals the tail index in that same cycle.
- Push while full: dropped and err set, even if retire_i is high in the same cycle.
- Pop:
  - Fires when retire_i && !empty; head++.
  - retire_i while empty: ignored and err set.
- Head read:
  - head_data_o and head_tag_o are combinational from the head index (zero read latency).
  - Data pushed in cycle N is visible at head in cycle N+1 when the buffer was empty.
- Push and pop in the same cycle: both take effect and count is unchanged. When empty, only the push happens.
- Wrap-around: pointers roll modulo 2^(LOGDEPTH+1), so the index wraps DEPTH-1 -> 0 seamlessly.
- Priority, highest first: reset > flush > squash > push/pop.
  - flush: head = tail = 0, next cycle empty. err is kept.
  - A push or pop in a flush cycle is discarded and does not set err.
- err_o is sticky until reset.

Optional Feature:
- Macro: BOB_SQUASH_EN.
- With the macro, mispredict rewind:
  - squash_i with squash_tag_i valid (index lies in [head, tail-1], modulo DEPTH, with count > 0): tail = head + ((squash_tag_i - head index) mod DEPTH) + 1.
  - The squashed branch's own entry is kept; all younger entries are dropped.
  - A push in the same cycle is discarded.
  - A pop in the same cycle still applies to head. If the pop removes the only surviving entry, the result is empty.
  - Squash with a tag that is not valid: ignored and err set.
- Without the macro: squash_i and squash_tag_i ports are absent. Only flush recovery exists.

Test Plan:
- Reset, then 16 pushes with data 0..15, no pops (DEPTH=16) -> alloc_tag_o 0..15; then full_o=1, alloc_rdy_o=0, count_o=16, head_data_o=0.
- Full, then push+pop in one cycle -> push dropped, err_o=1, count_o=15, head_tag_o=1.
- Fill 10, pop 10, push 10 more -> tags 10..15 then 0..3; FIFO order kept across wrap; empty_o=1 after final 10 pops.
- Push+pop on every cycle for 40 cycles starting at count 3 -> count_o stays 3; payload order preserved.
- Pop while empty -> state unchanged, err_o=1. flush with count 7 -> next cycle count_o=0, head_vld_o=0, err_o unchanged.
- BOB_SQUASH_EN: head=2, entries at tags 2..9, squash_tag_i=5 -> count_o=4, next alloc_tag_o=6. squash_tag_i=12 -> ignored, err_o=1.
